lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: latches one request, issues an aligned memory access, extends load data.
// Optional LSU_MISALIGNED_SPLIT_EN splits word-crossing accesses into two memory accesses.
module lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic              req_write_i,
  input  logic              req_signed_i,
  input  logic [4:0]        req_rd_i,
  input  logic [1:0]        req_size_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_write_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_be_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic [4:0]        rsp_rd_o,
  output logic              rsp_fault_o
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam int SPAN  = 2;
`else
  localparam int SPAN  = 1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
`ifdef LSU_MISALIGNED_SPLIT_EN
    ,
    REQ2,
    WAIT2
`endif
  } state_t;

  state_t state_q, state_d, after_lo;

  logic [ADDR_W-1:0]    addr_q;
  logic [XLEN-1:0]      wdata_q;
  logic                 write_q, signed_q;
  logic                 fault_q, flushed_q;
  logic [4:0]           rd_q;
  logic [1:0]           size_q;
  logic [SPAN*XLEN-1:0] rdata_q;

  logic                 accept, hs, req_fault, hi_part;
  logic [OFF_W-1:0]     off;
  logic [7:0]           len_mask;
  logic [SPAN*NB-1:0]   be_full;
  logic [SPAN*XLEN-1:0] wd_full, rd_sh;
  logic [XLEN-1:0]      sh, tmp, ld;
  logic [6:0]           nbits, pad;

  assign req_ready_o = (state_q == IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign hs          = mem_valid_o && mem_ready_i;

`ifndef LSU_MISALIGNED_SPLIT_EN
  logic [OFF_W-1:0] req_mask;
  assign req_mask = OFF_W'((4'd1 << req_size_i) - 4'd1);
`endif

  always_comb begin
    req_fault = (XLEN == 32) && (req_size_i == 2'd3);
`ifndef LSU_MISALIGNED_SPLIT_EN
    if ((req_addr_i[OFF_W-1:0] & req_mask) != '0)
      req_fault = 1'b1;
`endif
  end

  assign off = addr_q[OFF_W-1:0];

  always_comb begin
    unique case (size_q)
      2'd0:    len_mask = 8'h01;
      2'd1:    len_mask = 8'h03;
      2'd2:    len_mask = 8'h0f;
      default: len_mask = 8'hff;
    endcase
  end

  assign be_full = (SPAN*NB)'(len_mask) << off;
  assign wd_full = (SPAN*XLEN)'(wdata_q) << {off, 3'b000};

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign hi_part     = (state_q == REQ2);
  assign after_lo    = (|be_full[2*NB-1:NB]) ? REQ2 : RESP;
  assign mem_valid_o = (state_q == REQ) || (state_q == REQ2);
  assign mem_be_o    = hi_part ? be_full[2*NB-1:NB] : be_full[NB-1:0];
  assign mem_wdata_o = hi_part ? wd_full[2*XLEN-1:XLEN] : wd_full[XLEN-1:0];
`else
  assign hi_part     = 1'b0;
  assign after_lo    = RESP;
  assign mem_valid_o = (state_q == REQ);
  assign mem_be_o    = be_full;
  assign mem_wdata_o = wd_full;
`endif

  assign mem_addr_o  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                     + (hi_part ? ADDR_W'(NB) : '0);
  assign mem_write_o = write_q;

  // Shift the selected bytes to the top, then back down to extend.
  assign rd_sh = rdata_q >> {off, 3'b000};
  assign sh    = rd_sh[XLEN-1:0];
  assign nbits = 7'd8 << size_q;
  assign pad   = (nbits >= 7'(XLEN)) ? 7'd0 : 7'(XLEN) - nbits;
  assign tmp   = sh << pad;

  always_comb begin
    if (signed_q) ld = $signed(tmp) >>> pad;
    else          ld = tmp >> pad;
  end

  assign rsp_valid_o = (state_q == RESP) && !flushed_q && !flush_i;
  assign rsp_fault_o = rsp_valid_o && fault_q;
  assign rsp_rd_o    = rd_q;
  assign rsp_data_o  = (rsp_valid_o && !write_q && !fault_q) ? ld : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = req_fault ? RESP : REQ;
      REQ: begin
        if (hs)           state_d = (write_q || mem_rvalid_i) ? after_lo : WAIT;
        else if (flush_i) state_d = IDLE;
      end
      WAIT: if (mem_rvalid_i) state_d = after_lo;
`ifdef LSU_MISALIGNED_SPLIT_EN
      REQ2:  if (hs) state_d = (write_q || mem_rvalid_i) ? RESP : WAIT2;
      WAIT2: if (mem_rvalid_i) state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
      fault_q   <= 1'b0;
      flushed_q <= 1'b0;
      rd_q      <= '0;
      size_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q    <= req_addr_i;
        wdata_q   <= req_wdata_i;
        write_q   <= req_write_i;
        signed_q  <= req_signed_i;
        fault_q   <= req_fault;
        flushed_q <= 1'b0;
        rd_q      <= req_rd_i;
        size_q    <= req_size_i;
      end else if (flush_i && state_q != IDLE) begin
        flushed_q <= 1'b1;
      end
      if (mem_rvalid_i && ((state_q == REQ && mem_ready_i) || state_q == WAIT))
        rdata_q[XLEN-1:0] <= mem_rdata_i;
`ifdef LSU_MISALIGNED_SPLIT_EN
      if (mem_rvalid_i && ((state_q == REQ2 && mem_ready_i) || state_q == WAIT2))
        rdata_q[2*XLEN-1:XLEN] <= mem_rdata_i;
`endif
    end
  end

endmodule
